// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// The optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ARB_NREQ           = 4;
   localparam int ARB_IDW            = 2;
   localparam int ARB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_arbiter_4_onehot_enc.sv
// One-hot to binary encoder for the 4-bit grant vector; all-zero input encodes
// to 0 and is qualified downstream by gnt_valid.
module onehot_enc_4to2
   import arb_pkg::*;
(
   input  logic [ARB_NREQ-1:0] onehot,
   output logic [ARB_IDW-1:0]  bin
);

   assign bin = {onehot[3] | onehot[2], onehot[3] | onehot[1]};

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold and direct handover.
// Define ARB_TIMEOUT_EN to add forced revocation after TIMEOUT_CYCLES of ownership.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int NREQ           = ARB_NREQ,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   output logic [NREQ-1:0]    gnt,
   output logic [ARB_IDW-1:0] gnt_id,
   output logic               gnt_valid,
   output logic               timeout
);

   arb_state_t          state_q, state_d;
   logic [ARB_IDW-1:0]  owner_q, owner_d;
   logic [ARB_IDW-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                valid_q;
   logic [2:0]          pick;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]          hold_cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
   logic [NREQ-1:0]     others;
`endif

   // Returns {found, index}: first set bit of r searching p, p+1, p+2, p+3 (mod 4).
   // Scanning downward lets the smallest offset overwrite the result last.
   function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [ARB_IDW-1:0] p);
      logic [2:0]         res;
      logic [ARB_IDW-1:0] idx;
      res = '0;
      for (int i = ARB_NREQ - 1; i >= 0; i--) begin
         idx = p + ARB_IDW'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      pick    = '0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = hold_cnt_q;
      timeout_d = 1'b0;
      others    = '0;
`endif
      case (state_q)
         IDLE: begin
            pick = rr_pick(req, ptr_q);
            if (pick[2]) begin
               state_d = GRANT;
               owner_d = pick[1:0];
               ptr_d   = pick[1:0] + 2'd1;
               gnt_d   = NREQ'(1) << pick[1:0];
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         GRANT: begin
            // The owner's own bit is low on release, so it can never re-win here.
            if (!req[owner_q]) begin
               pick = rr_pick(req, ptr_q);
               if (pick[2]) begin
                  owner_d = pick[1:0];
                  ptr_d   = pick[1:0] + 2'd1;
                  gnt_d   = NREQ'(1) << pick[1:0];
`ifdef ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt_q == HOLD_LAST) begin
               others = req & ~(NREQ'(1) << owner_q);
               pick   = rr_pick(others, ptr_q);
               cnt_d  = '0;
               if (pick[2]) begin
                  owner_d   = pick[1:0];
                  ptr_d     = pick[1:0] + 2'd1;
                  gnt_d     = NREQ'(1) << pick[1:0];
                  timeout_d = 1'b1;
               end
            end else begin
               cnt_d = hold_cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         valid_q <= |gnt_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign gnt       = gnt_q;
   assign gnt_valid = valid_q;

   onehot_enc_4to2 u_enc (
      .onehot (gnt_q),
      .bin    (gnt_id)
   );

endmodule
